rotating_register_file: RTL and testbench
=========================================

Name: rotating_register_file

Overview:
- Parametrised successor to the CGRA per-PE 1-write/2-read register file.
- Generalises width, depth, write-port count and read-port count.
- Adds rotating-register addressing for modulo-scheduled loops, a per-entry written-valid scoreboard, optional write-to-read bypass, and a synchronous flush.
- Sits inside each CGRA processing element, between the FU result mux and the operand muxes.

Parameters:
- LOG2REGS, 3, log2 of entry count (N = 2**LOG2REGS).
- SIZE, 32, data width in bits.
- NUM_WR, 2, write ports.
- NUM_RD, 2, read ports.
- RESET_VALUE, 1, value loaded into every entry on reset/flush.
- BYPASS, 1, 1 = a same-cycle write to the read entry is forwarded to the read output; 0 = the read returns the old contents.

Ports:
- CGRA_Clock  in  1  clock; all state updates on rising edge.
- CGRA_Reset  in  1  one clock; reset is synchronous and active-low (CGRA_Reset = 0 resets on the next rising CGRA_Clock edge).
- WE  in  NUM_WR  per-port write enable.
- address_in  in  NUM_WR*LOG2REGS  logical write addresses; port k is at bits [k*LOG2REGS +: LOG2REGS].
- in  in  NUM_WR*SIZE  write data; port k is at bits [k*SIZE +: SIZE].
- address_out  in  NUM_RD*LOG2REGS  logical read addresses.
- out  out  NUM_RD*SIZE  registered read data.
- out_valid  out  NUM_RD  registered: the read entry has been written since the last reset/flush.
- rotate  in  1  advance the rotation base at the end of the cycle (iteration boundary).
- flush  in  1  synchronous clear of contents, scoreboard and base.
- rrb  out  LOG2REGS  current rotation base.

Behaviour:
- Reset (CGRA_Reset = 0 at an edge):
  - all entries = RESET_VALUE; all valid bits = 0; rrb = 0; out = 0; out_valid = 0.
  - WE, rotate and flush are ignored in that cycle.
- Flush (reset high, flush = 1):
  - same effect as reset on entries, valid bits and rrb.
  - out = 0, out_valid = 0 on the next cycle.
  - writes and rotate in that cycle are discarded.
- Address translation: physical = (logical + rrb) mod N, unsigned wrap-around.
  - All writes and reads in a cycle use the rrb value held at the start of that cycle.
- Rotate:
  - rrb <= (rrb + 1) mod N at the edge; wraps from N-1 to 0.
  - The register contents do not move.
- Writes:
  - For each k with WE[k] = 1: entry[phys_k] <= in_k and valid[phys_k] <= 1.
  - Two or more ports to the same physical entry: the highest-indexed port wins (deterministic; no error flag).
- Reads: one-cycle latency.
  - out_j and out_valid_j at edge t+1 reflect address_out_j sampled at edge t.
  - BYPASS = 1 and a write to the same physical entry in the same cycle: out_j = winning write data, out_valid_j = 1.
  - BYPASS = 0: out_j = pre-write contents, out_valid_j = pre-write valid bit.
- Priority: reset > flush > {writes, rotate, reads}. Writes and rotate may occur together in one cycle.
- No combinational path from any input to out, out_valid or rrb.

Test Plan:
- Reset, then read logical 0..7 on both ports -> out = 1, out_valid = 0 for every address; rrb = 0.
- WE = 2'b01, address 3, data 0xDEAD_BEEF, then read address 3 -> out0 = 0xDEADBEEF and out_valid0 = 1 one cycle later; address 4 still reads 1 with valid 0.
- Both ports write logical 5 (port0 = 0xAAAA, port1 = 0x5555) -> entry 5 reads 0x5555; with BYPASS = 1 a same-cycle read of 5 returns 0x5555.
- Write logical 2 = 0x22 with rrb = 0; rotate twice -> rrb = 2; logical 0 now reads 0x22. Rotate 6 more times -> rrb wraps to 0.
- Write + rotate + read in the same cycle at rrb = 7, logical 1 = 0x77 -> stored at physical 0; after the edge rrb = 0, and logical 0 reads 0x77.
- Mid-operation, assert flush together with WE; in a separate run, pull CGRA_Reset low while rotate = 1 -> in both cases all entries = 1, valid bits = 0, rrb = 0, and the concurrent write is not stored.

Source files
------------

// File: rtl/rotating_register_file.sv
// Multi-port register file with rotating-base addressing, per-entry written-valid
// scoreboard, optional write-to-read forwarding and synchronous flush.
module rotating_register_file #(
  parameter int LOG2REGS    = 3,
  parameter int SIZE        = 32,
  parameter int NUM_WR      = 2,
  parameter int NUM_RD      = 2,
  parameter int RESET_VALUE = 1,
  parameter int BYPASS      = 1
) (
  input  logic                       CGRA_Clock,
  input  logic                       CGRA_Reset,
  input  logic [NUM_WR-1:0]          WE,
  input  logic [NUM_WR*LOG2REGS-1:0] address_in,
  input  logic [NUM_WR*SIZE-1:0]     in,
  input  logic [NUM_RD*LOG2REGS-1:0] address_out,
  output logic [NUM_RD*SIZE-1:0]     out,
  output logic [NUM_RD-1:0]          out_valid,
  input  logic                       rotate,
  input  logic                       flush,
  output logic [LOG2REGS-1:0]        rrb
);

  localparam int N = 2 ** LOG2REGS;
  localparam logic [SIZE-1:0] RST_WORD = SIZE'(RESET_VALUE);

  logic [SIZE-1:0]     mem      [N];
  logic [N-1:0]        valid;
  logic [LOG2REGS-1:0] wr_phys  [NUM_WR];
  logic [LOG2REGS-1:0] rd_phys  [NUM_RD];
  logic [SIZE-1:0]     rd_data  [NUM_RD];
  logic [NUM_RD-1:0]   rd_valid;

  // Translation uses the base held at the start of the cycle; the sum wraps mod N.
  always_comb begin
    for (int k = 0; k < NUM_WR; k++) begin
      wr_phys[k] = address_in[k*LOG2REGS +: LOG2REGS] + rrb;
    end
    for (int j = 0; j < NUM_RD; j++) begin
      rd_phys[j]  = address_out[j*LOG2REGS +: LOG2REGS] + rrb;
      rd_data[j]  = mem[rd_phys[j]];
      rd_valid[j] = valid[rd_phys[j]];
      if (BYPASS != 0) begin
        // Ascending scan so the highest-indexed matching port is forwarded.
        for (int k = 0; k < NUM_WR; k++) begin
          if (WE[k] && (wr_phys[k] == rd_phys[j])) begin
            rd_data[j]  = in[k*SIZE +: SIZE];
            rd_valid[j] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CGRA_Clock) begin
    if (!CGRA_Reset || flush) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= RST_WORD;
      end
      valid     <= '0;
      rrb       <= '0;
      out       <= '0;
      out_valid <= '0;
    end else begin
      // Later ports override earlier ones on a shared entry.
      for (int k = 0; k < NUM_WR; k++) begin
        if (WE[k]) begin
          mem[wr_phys[k]]   <= in[k*SIZE +: SIZE];
          valid[wr_phys[k]] <= 1'b1;
        end
      end
      if (rotate) begin
        rrb <= rrb + LOG2REGS'(1);
      end
      for (int j = 0; j < NUM_RD; j++) begin
        out[j*SIZE +: SIZE] <= rd_data[j];
      end
      out_valid <= rd_valid;
    end
  end

endmodule

// File: tb/tb_rotating_register_file.sv
// Directed bench for rotating_register_file (default parameters: 8 x 32, 2W/2R, bypass on).
module tb_rotating_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  we;
  logic [5:0]  waddr;
  logic [63:0] wdata;
  logic [5:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rvalid;
  logic        rot;
  logic        fl;
  logic [2:0]  base;

  int checks = 0;
  int failures = 0;

  rotating_register_file dut (
    .CGRA_Clock (clk),
    .CGRA_Reset (rst_n),
    .WE         (we),
    .address_in (waddr),
    .in         (wdata),
    .address_out(raddr),
    .out        (rdata),
    .out_valid  (rvalid),
    .rotate     (rot),
    .flush      (fl),
    .rrb        (base)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned rst_n, flush, rotate, we;
    int unsigned wa0, wa1, wd0, wd1, ra0, ra1;
    int unsigned eo0, eo1, ev, er;
  } vec_t;

  vec_t tv [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then check the registered outputs just after the edge.
  task automatic run(input vec_t v, input string tag);
    rst_n = v.rst_n[0];
    fl    = v.flush[0];
    rot   = v.rotate[0];
    we    = v.we[1:0];
    waddr = {v.wa1[2:0], v.wa0[2:0]};
    wdata = {v.wd1, v.wd0};
    raddr = {v.ra1[2:0], v.ra0[2:0]};
    @(posedge clk);
    #1;
    chk({tag, " out0"}, rdata[31:0], v.eo0);
    chk({tag, " out1"}, rdata[63:32], v.eo1);
    chk({tag, " out_valid"}, {30'd0, rvalid}, {30'd0, v.ev[1:0]});
    chk({tag, " rrb"}, {29'd0, base}, {29'd0, v.er[2:0]});
  endtask

  initial begin
    rst_n = 1'b0; fl = 1'b0; rot = 1'b0; we = '0;
    waddr = '0; wdata = '0; raddr = '0;

    //        rst fl rot we wa0 wa1 wd0           wd1       ra0 ra1 eo0           eo1           ev     er
    tv[0]  = '{0, 0, 1, 1, 3, 0, 32'h99,        0,        0, 0, 0,            0,            2'b00, 0};
    tv[1]  = '{1, 0, 0, 0, 0, 0, 0,             0,        0, 1, 1,            1,            2'b00, 0};
    tv[2]  = '{1, 0, 0, 0, 0, 0, 0,             0,        2, 3, 1,            1,            2'b00, 0};
    tv[3]  = '{1, 0, 0, 0, 0, 0, 0,             0,        4, 5, 1,            1,            2'b00, 0};
    tv[4]  = '{1, 0, 0, 0, 0, 0, 0,             0,        6, 7, 1,            1,            2'b00, 0};
    tv[5]  = '{1, 0, 0, 1, 3, 0, 32'hDEADBEEF,  0,        0, 4, 1,            1,            2'b00, 0};
    tv[6]  = '{1, 0, 0, 0, 0, 0, 0,             0,        3, 4, 32'hDEADBEEF, 1,            2'b01, 0};
    tv[7]  = '{1, 0, 0, 3, 5, 5, 32'hAAAA,      32'h5555, 5, 5, 32'h5555,     32'h5555,     2'b11, 0};
    tv[8]  = '{1, 0, 0, 0, 0, 0, 0,             0,        5, 3, 32'h5555,     32'hDEADBEEF, 2'b11, 0};
    tv[9]  = '{1, 0, 0, 1, 2, 0, 32'h22,        0,        0, 2, 1,            32'h22,       2'b10, 0};
    tv[10] = '{1, 0, 1, 0, 0, 0, 0,             0,        2, 0, 32'h22,       1,            2'b01, 1};
    tv[11] = '{1, 0, 1, 0, 0, 0, 0,             0,        0, 1, 1,            32'h22,       2'b10, 2};
    tv[12] = '{1, 0, 0, 0, 0, 0, 0,             0,        0, 1, 32'h22,       32'hDEADBEEF, 2'b11, 2};
    tv[13] = '{1, 0, 1, 0, 0, 0, 0,             0,        0, 0, 32'h22,       32'h22,       2'b11, 3};
    tv[14] = '{1, 0, 1, 0, 0, 0, 0,             0,        0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 4};
    tv[15] = '{1, 0, 1, 0, 0, 0, 0,             0,        0, 0, 1,            1,            2'b00, 5};
    tv[16] = '{1, 0, 1, 0, 0, 0, 0,             0,        0, 0, 32'h5555,     32'h5555,     2'b11, 6};
    tv[17] = '{1, 0, 1, 0, 0, 0, 0,             0,        0, 0, 1,            1,            2'b00, 7};
    tv[18] = '{1, 0, 1, 1, 1, 0, 32'h77,        0,        1, 0, 32'h77,       1,            2'b01, 0};
    tv[19] = '{1, 0, 0, 0, 0, 0, 0,             0,        0, 7, 32'h77,       1,            2'b01, 0};
    tv[20] = '{1, 0, 1, 0, 0, 0, 0,             0,        0, 7, 32'h77,       1,            2'b01, 1};
    tv[21] = '{1, 1, 1, 1, 6, 0, 32'h66,        0,        0, 0, 0,            0,            2'b00, 0};
    tv[22] = '{1, 0, 0, 0, 0, 0, 0,             0,        6, 5, 1,            1,            2'b00, 0};
    tv[23] = '{1, 0, 1, 2, 0, 4, 0,             32'h44,   4, 0, 32'h44,       1,            2'b01, 1};
    tv[24] = '{0, 0, 1, 1, 2, 0, 32'h55,        0,        0, 0, 0,            0,            2'b00, 0};
    tv[25] = '{1, 0, 0, 0, 0, 0, 0,             0,        4, 2, 1,            1,            2'b00, 0};

    for (int i = 0; i < 26; i++) begin
      run(tv[i], $sformatf("vec%0d", i));
    end

    // Independent ports, back-to-back writes to one entry, and a port-1-only forward.
    run('{1, 0, 0, 3, 1, 6, 32'h11, 32'h66, 1, 6, 32'h11, 32'h66, 2'b11, 0}, "seq_dual_wr");
    run('{1, 0, 0, 1, 7, 0, 32'hA,  0,      1, 6, 32'h11, 32'h66, 2'b11, 0}, "seq_wr7_a");
    run('{1, 0, 0, 2, 0, 7, 0,      32'hB,  7, 7, 32'hB,  32'hB,  2'b11, 0}, "seq_wr7_b");
    run('{1, 0, 0, 0, 0, 0, 0,      0,      7, 0, 32'hB,  1,      2'b01, 0}, "seq_rd7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
